// File: rtl/rom_download_writer_if.sv
// Word-write port between the download packer and the cartridge-ROM memory controller.
interface rom_download_writer_if #(
    parameter int unsigned ADDR_W = 22
);
    logic              mem_req;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic [1:0]        mem_be;

    modport master (output mem_req, mem_addr, mem_din, mem_be, input mem_ack);
    modport slave  (input mem_req, mem_addr, mem_din, mem_be, output mem_ack);
endinterface

// File: rtl/rom_download_writer.sv
// Packs SPI download byte strobes into 16-bit words, buffers them in a small FIFO and
// writes them to the ROM controller over req/ack; also tracks count, checksum and completion.
module rom_download_writer #(
    parameter int unsigned       ADDR_W     = 22,
    parameter logic [ADDR_W-1:0] BASE_WORD  = '0,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dl_downloading,
    input  logic                  dl_wr,
    input  logic [15:0]           dl_addr,
    input  logic [7:0]            dl_data,
    rom_download_writer_if.master mem,
    output logic                  busy,
    output logic                  done,
    output logic [16:0]           byte_count,
    output logic [15:0]           checksum,
    output logic                  overflow
);
    localparam int unsigned    PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    typedef struct packed {
        logic [14:0] waddr;
        logic [15:0] din;
        logic [1:0]  be;
    } word_t;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    function automatic word_t make_word(input logic [14:0] waddr, input logic [15:0] din,
                                        input logic [1:0] be);
        word_t w;
        w.waddr = waddr;
        w.din   = din;
        w.be    = be;
        return w;
    endfunction

    logic        dl_prev_q;
    logic        rise, fall;
    logic        armed_q;

    logic        p_valid_q, p_valid_d;
    logic [14:0] p_waddr_q, p_waddr_d;
    logic [7:0]  p_data_q,  p_data_d;
    logic        d_valid_q, d_valid_d;
    logic [14:0] d_waddr_q, d_waddr_d;
    logic [7:0]  d_data_q,  d_data_d;

    logic        push, push_ok, pop, load;
    word_t       push_word, head;
    word_t       fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full;

    state_t      state_q, state_d;

    assign rise = dl_downloading & ~dl_prev_q;
    assign fall = ~dl_downloading & dl_prev_q;

    // Byte packer. Sources of a push are mutually exclusive: the deferred odd byte only
    // exists the cycle after a strobe, and the end-of-download flush waits for both.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        p_valid_d = p_valid_q;
        p_waddr_d = p_waddr_q;
        p_data_d  = p_data_q;
        d_valid_d = 1'b0;
        d_waddr_d = d_waddr_q;
        d_data_d  = d_data_q;

        if (d_valid_q) begin
            push      = 1'b1;
            push_word = make_word(d_waddr_q, {d_data_q, 8'h00}, 2'b10);
        end

        if (dl_wr) begin
            if (!dl_addr[0]) begin
                if (p_valid_q) begin
                    push      = 1'b1;
                    push_word = make_word(p_waddr_q, {8'h00, p_data_q}, 2'b01);
                end
                p_valid_d = 1'b1;
                p_waddr_d = dl_addr[15:1];
                p_data_d  = dl_data;
            end else if (p_valid_q && (p_waddr_q == dl_addr[15:1])) begin
                push      = 1'b1;
                push_word = make_word(p_waddr_q, {dl_data, p_data_q}, 2'b11);
                p_valid_d = 1'b0;
            end else begin
                if (p_valid_q) begin
                    push      = 1'b1;
                    push_word = make_word(p_waddr_q, {8'h00, p_data_q}, 2'b01);
                end
                p_valid_d = 1'b0;
                d_valid_d = 1'b1;
                d_waddr_d = dl_addr[15:1];
                d_data_d  = dl_data;
            end
        end else if (!dl_downloading && p_valid_q && !d_valid_q) begin
            push      = 1'b1;
            push_word = make_word(p_waddr_q, {8'h00, p_data_q}, 2'b01);
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_valid_q <= 1'b0;
            p_waddr_q <= '0;
            p_data_q  <= '0;
            d_valid_q <= 1'b0;
            d_waddr_q <= '0;
            d_data_q  <= '0;
        end else begin
            p_valid_q <= p_valid_d;
            p_waddr_q <= p_waddr_d;
            p_data_q  <= p_data_d;
            d_valid_q <= d_valid_d;
            d_waddr_q <= d_waddr_d;
            d_data_q  <= d_data_d;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_ok    = push & ~fifo_full;
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Writer: returning to IDLE on ack guarantees one low cycle of mem_req between words.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_REQ;
                    load    = 1'b1;
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    state_d = S_IDLE;
                    pop     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            mem.mem_addr <= '0;
            mem.mem_din  <= '0;
            mem.mem_be   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                mem.mem_addr <= BASE_WORD + ADDR_W'(head.waddr);
                mem.mem_din  <= head.din;
                mem.mem_be   <= head.be;
            end
        end
    end

    assign mem.mem_req = (state_q == S_REQ);

    assign busy = p_valid_q | d_valid_q | ~fifo_empty | mem.mem_req;
    assign done = (armed_q | fall) & ~dl_downloading & ~dl_wr & ~p_valid_q & ~d_valid_q &
                  fifo_empty & (state_q == S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_prev_q  <= 1'b0;
            armed_q    <= 1'b0;
            byte_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
        end else begin
            dl_prev_q <= dl_downloading;

            if (rise) begin
                byte_count <= dl_wr ? 17'd1 : 17'd0;
                checksum   <= dl_wr ? {8'h00, dl_data} : 16'h0000;
            end else if (dl_wr) begin
                byte_count <= byte_count + 17'd1;
                checksum   <= checksum + {8'h00, dl_data};
            end

            if (push && fifo_full) overflow <= 1'b1;
            else if (rise)         overflow <= 1'b0;

            if (rise)      armed_q <= 1'b0;
            else if (done) armed_q <= 1'b0;
            else if (fall) armed_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rom_download_writer.sv
// Self-checking bench for rom_download_writer: spec vectors, overflow/reset sequences and
// randomized downloads against a byte-level packing model.
module tb_rom_download_writer;
    localparam int unsigned       ADDR_W = 22;
    localparam logic [ADDR_W-1:0] BASE   = 22'h100000;
    localparam int unsigned       DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       din;
        logic [1:0]        be;
    } wr_t;

    typedef struct {
        int          nb;
        logic [15:0] a [4];
        logic [7:0]  d [4];
        int          ack_dly;
        int          nw;
        logic [14:0] ww [2];
        logic [15:0] wd [2];
        logic [1:0]  wb [2];
        logic [16:0] cnt;
        logic [15:0] cs;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_downloading = 1'b0;
    logic        dl_wr = 1'b0;
    logic [15:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        busy, done, overflow;
    logic [16:0] byte_count;
    logic [15:0] checksum;

    rom_download_writer_if #(.ADDR_W(ADDR_W)) mif ();

    rom_download_writer #(.ADDR_W(ADDR_W), .BASE_WORD(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dl_downloading (dl_downloading),
        .dl_wr          (dl_wr),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .mem            (mif),
        .busy           (busy),
        .done           (done),
        .byte_count     (byte_count),
        .checksum       (checksum),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          ack_delay = 0;
    bit          ack_hold = 1'b0;
    bit          rand_ack = 1'b0;
    wr_t         obs_q [$];
    wr_t         exp_q [$];
    logic [15:0] byte_a [$];
    logic [7:0]  byte_d [$];
    vec_t        tbl [4];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] masked(logic [15:0] din, logic [1:0] be);
        return {be[1] ? din[15:8] : 8'h00, be[0] ? din[7:0] : 8'h00};
    endfunction

    function automatic void push_exp(logic [14:0] w, logic [15:0] din, logic [1:0] be);
        wr_t e;
        e.addr = BASE + ADDR_W'(w);
        e.din  = din;
        e.be   = be;
        exp_q.push_back(e);
    endfunction

    // Memory-controller model: records each word, acks after a delay, checks stability.
    initial begin : responder
        wr_t cap;
        bit  in_req;
        int  wait_cnt;
        int  dly;
        in_req = 1'b0;
        wait_cnt = 0;
        dly = 0;
        cap.addr = '0;
        cap.din = '0;
        cap.be = '0;
        mif.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_req = 1'b0;
                mif.mem_ack = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (mif.mem_ack) begin
                    mif.mem_ack = 1'b0;
                    in_req = 1'b0;
                    check("req_low_after_ack", mif.mem_req, 0);
                end else if (mif.mem_req) begin
                    if (!in_req) begin
                        in_req = 1'b1;
                        cap.addr = mif.mem_addr;
                        cap.din = mif.mem_din;
                        cap.be = mif.mem_be;
                        obs_q.push_back(cap);
                        wait_cnt = 0;
                        dly = rand_ack ? int'($urandom_range(0, 2)) : ack_delay;
                    end else begin
                        check("addr_stable", mif.mem_addr, cap.addr);
                        check("din_stable", mif.mem_din, cap.din);
                        check("be_stable", mif.mem_be, cap.be);
                    end
                    if (!ack_hold) begin
                        if (wait_cnt >= dly) mif.mem_ack = 1'b1;
                        else wait_cnt++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input int gap);
        dl_addr = a;
        dl_data = d;
        dl_wr = 1'b1;
        byte_a.push_back(a);
        byte_d.push_back(d);
        tick();
        dl_wr = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic start_download();
        obs_q.delete();
        exp_q.delete();
        byte_a.delete();
        byte_d.delete();
        dl_downloading = 1'b1;
        tick();
        tick();
        check("start_count", byte_count, 0);
        check("start_checksum", checksum, 0);
        check("start_overflow", overflow, 0);
        done_cnt = 0;
    endtask

    task automatic finish_download();
        int n;
        n = 0;
        dl_downloading = 1'b0;
        tick();
        while ((busy || mif.mem_req) && n < 400) begin
            tick();
            n++;
        end
        check("drain_in_time", n < 400, 1);
        repeat (5) tick();
        check("done_pulses", done_cnt, 1);
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_nwords"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
            check({tag, "_be"}, obs_q[i].be, exp_q[i].be);
            check({tag, "_din"}, masked(obs_q[i].din, obs_q[i].be), exp_q[i].din);
        end
    endtask

    // Reference packing: pairs an even byte with the immediately following odd byte of the
    // same word; everything else is written alone, flushing the pending even byte first.
    task automatic build_expected();
        bit          pv;
        logic [14:0] pw;
        logic [7:0]  pd;
        logic [14:0] w;
        pv = 1'b0;
        pw = '0;
        pd = '0;
        exp_q.delete();
        for (int i = 0; i < byte_a.size(); i++) begin
            w = byte_a[i][15:1];
            if (!byte_a[i][0]) begin
                if (pv) push_exp(pw, {8'h00, pd}, 2'b01);
                pv = 1'b1;
                pw = w;
                pd = byte_d[i];
            end else if (pv && pw == w) begin
                push_exp(w, {byte_d[i], pd}, 2'b11);
                pv = 1'b0;
            end else begin
                if (pv) push_exp(pw, {8'h00, pd}, 2'b01);
                pv = 1'b0;
                push_exp(w, {byte_d[i], 8'h00}, 2'b10);
            end
        end
        if (pv) push_exp(pw, {8'h00, pd}, 2'b01);
    endtask

    initial begin : main
        logic [15:0] ra;
        logic [15:0] sum;
        int          n;

        tbl[0].nb = 4; tbl[0].a = '{16'h0, 16'h1, 16'h2, 16'h3};
        tbl[0].d = '{8'h11, 8'h22, 8'h33, 8'h44}; tbl[0].ack_dly = 2;
        tbl[0].nw = 2; tbl[0].ww = '{15'd0, 15'd1}; tbl[0].wd = '{16'h2211, 16'h4433};
        tbl[0].wb = '{2'b11, 2'b11}; tbl[0].cnt = 17'd4; tbl[0].cs = 16'h00AA;

        tbl[1].nb = 3; tbl[1].a = '{16'h0, 16'h1, 16'h2, 16'h0};
        tbl[1].d = '{8'hAA, 8'hBB, 8'hCC, 8'h00}; tbl[1].ack_dly = 0;
        tbl[1].nw = 2; tbl[1].ww = '{15'd0, 15'd1}; tbl[1].wd = '{16'hBBAA, 16'h00CC};
        tbl[1].wb = '{2'b11, 2'b01}; tbl[1].cnt = 17'd3; tbl[1].cs = 16'h0231;

        tbl[2].nb = 1; tbl[2].a = '{16'h7, 16'h0, 16'h0, 16'h0};
        tbl[2].d = '{8'h5A, 8'h00, 8'h00, 8'h00}; tbl[2].ack_dly = 1;
        tbl[2].nw = 1; tbl[2].ww = '{15'd3, 15'd0}; tbl[2].wd = '{16'h5A00, 16'h0000};
        tbl[2].wb = '{2'b10, 2'b00}; tbl[2].cnt = 17'd1; tbl[2].cs = 16'h005A;

        tbl[3].nb = 2; tbl[3].a = '{16'h0, 16'h5, 16'h0, 16'h0};
        tbl[3].d = '{8'h12, 8'h34, 8'h00, 8'h00}; tbl[3].ack_dly = 1;
        tbl[3].nw = 2; tbl[3].ww = '{15'd0, 15'd2}; tbl[3].wd = '{16'h0012, 16'h3400};
        tbl[3].wb = '{2'b01, 2'b10}; tbl[3].cnt = 17'd2; tbl[3].cs = 16'h0046;

        repeat (3) tick();
        check("rst_mem_req", mif.mem_req, 0);
        check("rst_mem_addr", mif.mem_addr, 0);
        check("rst_mem_din", mif.mem_din, 0);
        check("rst_mem_be", mif.mem_be, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_checksum", checksum, 0);
        check("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            ack_delay = tbl[i].ack_dly;
            start_download();
            for (int b = 0; b < tbl[i].nb; b++) send_byte(tbl[i].a[b], tbl[i].d[b], 2);
            exp_q.delete();
            for (int w = 0; w < tbl[i].nw; w++) push_exp(tbl[i].ww[w], tbl[i].wd[w], tbl[i].wb[w]);
            finish_download();
            compare_words($sformatf("vec%0d", i));
            check($sformatf("vec%0d_count", i), byte_count, tbl[i].cnt);
            check($sformatf("vec%0d_checksum", i), checksum, tbl[i].cs);
            check($sformatf("vec%0d_overflow", i), overflow, 0);
        end

        // FIFO overflow with the controller stalled.
        ack_delay = 1;
        start_download();
        ack_hold = 1'b1;
        for (int i = 0; i < 12; i++) send_byte(16'(i), 8'(16 + i), 2);
        repeat (3) tick();
        check("ovf_flag", overflow, 1);
        check("ovf_count", byte_count, 12);
        check("ovf_req_held", mif.mem_req, 1);
        exp_q.delete();
        for (int k = 0; k < 4; k++) push_exp(15'(k), {8'(17 + 2 * k), 8'(16 + 2 * k)}, 2'b11);
        ack_hold = 1'b0;
        finish_download();
        compare_words("ovf");
        check("ovf_sticky", overflow, 1);

        // Randomized download against the packing model.
        rand_ack = 1'b1;
        start_download();
        ra = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) ra = 16'($urandom);
            else ra = ra + 16'd1;
            send_byte(ra, 8'($urandom), int'($urandom_range(6, 10)));
        end
        build_expected();
        finish_download();
        compare_words("rand");
        sum = '0;
        foreach (byte_d[i]) sum = sum + {8'h00, byte_d[i]};
        check("rand_count", byte_count, 17'(byte_a.size()));
        check("rand_checksum", checksum, sum);
        check("rand_overflow", overflow, 0);
        rand_ack = 1'b0;

        // Asynchronous reset while a request is outstanding.
        start_download();
        ack_hold = 1'b1;
        send_byte(16'h0040, 8'h01, 2);
        send_byte(16'h0041, 8'h02, 2);
        n = 0;
        while (!mif.mem_req && n < 50) begin
            tick();
            n++;
        end
        check("arst_req_seen", mif.mem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req_drop", mif.mem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        dl_downloading = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        ack_hold = 1'b0;
        done_cnt = 0;
        repeat (20) tick();
        check("arst_no_done", done_cnt, 0);
        check("arst_idle_req", mif.mem_req, 0);
        check("arst_idle_busy", busy, 0);
        check("arst_count", byte_count, 0);
        obs_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
